// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter for the write port of the dual-clock FIFO.
//               Grants one requester at a time for a burst of up to MAX_BURST
//               words. Writes are held off while the FIFO reports Full, and
//               each accepted word is acknowledged to its requester.
//               Optional statistics counters: define FIFO_WR_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                      wCLK,
  input  logic                      wrst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   din,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [ID_W-1:0]           owner,
  output logic                      fifo_wr_req,
  output logic [DATA_W-1:0]         fifo_din,
  input  logic                      fifo_full
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       stat_words,
  output logic [15:0]               stat_stall
`endif
);

  localparam int              c_CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [0:0]      c_IDLE  = 1'b0;
  localparam logic [0:0]      c_BURST = 1'b1;
  localparam logic [N_REQ-1:0] c_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MAX_BURST - 1);

  logic [0:0]         r_state,     w_state_nxt;
  logic [ID_W-1:0]    r_owner,     w_owner_nxt;
  logic [N_REQ-1:0]   r_gnt,       w_gnt_nxt;
  logic [ID_W-1:0]    r_rr_ptr,    w_rr_nxt;
  logic [c_CNT_W-1:0] r_burst_cnt, w_cnt_nxt;

  logic               w_accept;
  logic               w_end;
  logic [ID_W-1:0]    w_owner_inc;
  logic [ID_W-1:0]    w_scan_base;
  logic [ID_W:0]      w_pick;
  logic               w_pick_vld;
  logic [ID_W-1:0]    w_pick_idx;

  // First set request bit scanning circularly upward from base.
  // Scanning from owner+1 puts the current owner last, so a requester that
  // just finished a full burst only re-wins when nobody else is asking.
  function automatic logic [ID_W:0] f_pick(input logic [N_REQ-1:0] r,
                                           input logic [ID_W-1:0]  base);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(base) + i) % N_REQ;
      if (r[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  assign w_owner_inc = (r_owner == ID_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_scan_base = (r_state == c_BURST) ? w_owner_inc : r_rr_ptr;
  assign w_pick      = f_pick(req, w_scan_base);
  assign w_pick_vld  = w_pick[ID_W];
  assign w_pick_idx  = w_pick[ID_W-1:0];

  assign w_accept = (r_state == c_BURST) & req[r_owner] & r_gnt[r_owner] & ~fifo_full;
  // Burst closes on the last allowed word or when the owner withdraws.
  assign w_end    = (w_accept & (r_burst_cnt == c_LAST)) | ~req[r_owner];

  // State register together with grant bookkeeping.
  always_ff @(posedge wCLK or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state     <= c_IDLE;
      r_owner     <= '0;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // Next-state: arbitrate from IDLE, count and close bursts in BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_burst_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_pick_vld) begin
          w_owner_nxt = w_pick_idx;
          w_gnt_nxt   = c_ONE << w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = c_BURST;
        end
      end
      c_BURST: begin
        if (w_end) begin
          w_rr_nxt  = w_owner_inc;
          w_cnt_nxt = '0;
          if (w_pick_vld) begin
            w_owner_nxt = w_pick_idx;
            w_gnt_nxt   = c_ONE << w_pick_idx;
          end else begin
            w_gnt_nxt   = '0;
            w_state_nxt = c_IDLE;
          end
        end else if (w_accept) begin
          w_cnt_nxt = r_burst_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Outputs: write strobe, per-requester ack and the owner's data word.
  always_comb begin
    ack         = '0;
    fifo_wr_req = w_accept;
    fifo_din    = '0;
    if (w_accept) ack = c_ONE << r_owner;
    if (|r_gnt)   fifo_din = din[int'(r_owner)*DATA_W +: DATA_W];
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ*16-1:0] r_stat_words;
  logic [15:0]         r_stat_stall;

  // Wrap-around counters: accepted words per requester and Full stall cycles.
  always_ff @(posedge wCLK or negedge wrst_n) begin
    if (!wrst_n) begin
      r_stat_words <= '0;
      r_stat_stall <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ack[i]) r_stat_words[i*16 +: 16] <= r_stat_words[i*16 +: 16] + 16'd1;
      end
      if ((r_state == c_BURST) && req[r_owner] && fifo_full)
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_words = r_stat_words;
  assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter. Directed scenarios
//               push the hand-derived write order into a scoreboard queue;
//               a negedge monitor pops and compares every FIFO write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             wCLK = 1'b0;
  logic             wrst_n = 1'b0;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic [1:0]       owner;
  logic             fifo_wr_req;
  logic [W-1:0]     fifo_din;
  logic             fifo_full;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0]  stat_words;
  logic [15:0]      stat_stall;
`endif

  int               n_checks = 0;
  int               n_fail = 0;
  int               rem [N];
  logic [W-1:0]     nxt [N];
  logic [N-1:0]     ack_n;
  logic [15:0]      exp_q [$];
  logic [15:0]      mon_e;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .wCLK        (wCLK),
    .wrst_n      (wrst_n),
    .req         (req),
    .din         (din),
    .gnt         (gnt),
    .ack         (ack),
    .owner       (owner),
    .fifo_wr_req (fifo_wr_req),
    .fifo_din    (fifo_din),
    .fifo_full   (fifo_full)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 wCLK = ~wCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester models: request while words remain, present the next word.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]         = (rem[i] > 0);
      din[i*W +: W]  = nxt[i];
    end
  endtask

  // One clock: sample ack at negedge, advance models after the edge.
  task automatic cycle();
    @(negedge wCLK);
    ack_n = ack;
    @(posedge wCLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_n[i]) begin
        rem[i] = rem[i] - 1;
        nxt[i] = nxt[i] + 8'd1;
      end
    end
    drive();
    #1;
  endtask

  task automatic push(input int o, input int base, input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back({8'(o), 8'(base + k)});
  endtask

  task automatic setup(input int i, input int words, input int base);
    rem[i] = words;
    nxt[i] = 8'(base);
  endtask

  task automatic run_until_empty(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < exp_cycles + 20) begin
      cycle();
      n++;
    end
    chk(name, 32'(n), 32'(exp_cycles));
    exp_q.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    fifo_full = 1'b0;
    drive();
    wrst_n = 1'b0;
    repeat (2) cycle();
    wrst_n = 1'b1;
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge wCLK) begin
    if (wrst_n) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("wr_eq_or_ack", 32'(fifo_wr_req), 32'(|ack));
      if (fifo_wr_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got din 0x%0h ack 0x%0h, expected no write", fifo_din, ack);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_data", 32'(fifo_din), 32'(mon_e[7:0]));
          chk("wr_owner", 32'(owner), 32'(mon_e[15:8]));
          chk("wr_ack", 32'(ack), 32'd1 << mon_e[15:8]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      nxt[i] = '0;
    end
    fifo_full = 1'b0;
    drive();
    wrst_n = 1'b0;
    repeat (2) cycle();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wr_req", 32'(fifo_wr_req), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
    chk("rst_burst_cnt", 32'(dut.r_burst_cnt), 32'd0);
    wrst_n = 1'b1;
    #1;

    // A: single requester, back-to-back bursts.
    do_reset();
    setup(0, 8, 8'h10);
    push(0, 8'h10, 8);
    drive();
    cycle();
    chk("A_gnt_after_req", 32'(gnt), 32'h1);
    run_until_empty("A_cycles_no_gap", 8);
    chk("A_wr_after_drop", 32'(fifo_wr_req), 32'd0);
    cycle();
    chk("A_gnt_idle", 32'(gnt), 32'd0);

    // B: all four requesting, owners 0,1,2,3,0.
    do_reset();
    setup(0, 8, 8'h20);
    setup(1, 4, 8'h30);
    setup(2, 4, 8'h40);
    setup(3, 4, 8'h50);
    push(0, 8'h20, 4);
    push(1, 8'h30, 4);
    push(2, 8'h40, 4);
    push(3, 8'h50, 4);
    push(0, 8'h24, 4);
    drive();
    cycle();
    chk("B_first_gnt", 32'(gnt), 32'h1);
    run_until_empty("B_cycles", 20);

    // C: Full stall in the middle of requester 2's burst.
    do_reset();
    setup(2, 4, 8'h60);
    push(2, 8'h60, 4);
    push(0, 8'h70, 1);
    drive();
    cycle();
    chk("C_gnt", 32'(gnt), 32'h4);
    repeat (2) cycle();
    fifo_full = 1'b1;
    setup(0, 1, 8'h70);
    drive();
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("C_stall_wr_req", 32'(fifo_wr_req), 32'd0);
      chk("C_stall_gnt", 32'(gnt), 32'h4);
      chk("C_stall_cnt", 32'(dut.r_burst_cnt), 32'd2);
      cycle();
    end
    fifo_full = 1'b0;
    drive();
    #1;
    chk("C_resume_wr_req", 32'(fifo_wr_req), 32'd1);
    chk("C_resume_din", 32'(fifo_din), 32'h62);
    run_until_empty("C_cycles", 3);
    chk("C_rotated_gnt", 32'(gnt), 32'h1);
    chk("C_rr_ptr", 32'(dut.r_rr_ptr), 32'd3);

    // D: requester 1 withdraws after one word while 3 waits.
    do_reset();
    setup(1, 1, 8'h80);
    setup(3, 2, 8'h90);
    push(1, 8'h80, 1);
    push(3, 8'h90, 2);
    drive();
    cycle();
    chk("D_gnt1", 32'(gnt), 32'h2);
    cycle();
    cycle();
    chk("D_gnt3", 32'(gnt), 32'h8);
    chk("D_rr_ptr", 32'(dut.r_rr_ptr), 32'd2);
    run_until_empty("D_cycles", 2);

    // E: asynchronous reset in the middle of a burst.
    do_reset();
    setup(0, 10, 8'hA0);
    setup(2, 8, 8'hB0);
    push(0, 8'hA0, 4);
    push(2, 8'hB0, 2);
    drive();
    cycle();
    chk("E_gnt0", 32'(gnt), 32'h1);
    run_until_empty("E_cycles_pre", 6);
    chk("E_wr_before_rst", 32'(fifo_wr_req), 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("E_rst_gnt", 32'(gnt), 32'd0);
    chk("E_rst_ack", 32'(ack), 32'd0);
    chk("E_rst_wr_req", 32'(fifo_wr_req), 32'd0);
    chk("E_rst_din", 32'(fifo_din), 32'd0);
    repeat (2) cycle();
    wrst_n = 1'b1;
    push(0, 8'hA4, 4);
    cycle();
    chk("E_post_gnt", 32'(gnt), 32'h1);
    chk("E_post_owner", 32'(owner), 32'd0);
    run_until_empty("E_cycles_post", 4);
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();

`ifdef FIFO_WR_ARB_STATS_EN
    // F: statistics over 64 words with a 5-cycle Full stall.
    begin
      int sum;
      do_reset();
      setup(0, 16, 8'h00);
      setup(1, 16, 8'h40);
      setup(2, 16, 8'h80);
      setup(3, 16, 8'hC0);
      for (int r = 0; r < 4; r++)
        for (int o = 0; o < 4; o++) push(o, o * 64 + r * 4, 4);
      drive();
      cycle();
      repeat (10) cycle();
      fifo_full = 1'b1;
      drive();
      repeat (5) cycle();
      fifo_full = 1'b0;
      drive();
      run_until_empty("F_cycles", 54);
      sum = 0;
      for (int i = 0; i < N; i++) sum += int'(stat_words[i*16 +: 16]);
      chk("F_stat_words_sum", 32'(sum), 32'd64);
      chk("F_stat_words_r3", 32'(stat_words[48 +: 16]), 32'd16);
      chk("F_stat_stall", 32'(stat_stall), 32'd5);
    end
`endif

    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
